// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  // Opcodes taken from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control codes, zero-extended to the output width at the top level
  localparam logic [3:0] ALU_ADDI = 4'b0000;
  localparam logic [3:0] ALU_ORI  = 4'b0001;
  localparam logic [3:0] ALU_R    = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_LW   = 4'b0100;
  localparam logic [3:0] ALU_SW   = 4'b0101;
  localparam logic [3:0] ALU_SLTI = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_BGTZ = 4'b1001;

  // ALU operand B source select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Result of decoding one opcode
  typedef struct packed {
    state_t     dispatch;
    logic [3:0] alu_op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the control unit (master) and the multi-cycle datapath (slave).
interface mc_control_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         OP;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               Branch;
  logic               IorD;
  logic               IRWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               MemToReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOP;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, Branch, IorD, IRWrite, MemRead, MemWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP,
           instr_done, illegal_op
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, Branch, IorD, IRWrite, MemRead, MemWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP,
           instr_done, illegal_op
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode decoder: OP -> {dispatch state, ALU code, legal}.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit BGTZ_EN = 1'b1
) (
  input  logic [5:0] op,
  output dec_t       dec
);

  // Map each supported opcode to its first post-decode state and ALU code
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dec = '{dispatch: S_FETCH, alu_op: 4'b0000, legal: 1'b0};
    case (op)
      OP_RTYPE: dec = '{dispatch: S_EXEC_R,   alu_op: ALU_R,    legal: 1'b1};
      OP_ADDI:  dec = '{dispatch: S_EXEC_I,   alu_op: ALU_ADDI, legal: 1'b1};
      OP_ORI:   dec = '{dispatch: S_EXEC_I,   alu_op: ALU_ORI,  legal: 1'b1};
      OP_ANDI:  dec = '{dispatch: S_EXEC_I,   alu_op: ALU_ANDI, legal: 1'b1};
      OP_SLTI:  dec = '{dispatch: S_EXEC_I,   alu_op: ALU_SLTI, legal: 1'b1};
      OP_LW:    dec = '{dispatch: S_MEM_ADDR, alu_op: ALU_LW,   legal: 1'b1};
      OP_SW:    dec = '{dispatch: S_MEM_ADDR, alu_op: ALU_SW,   legal: 1'b1};
      OP_BEQ:   dec = '{dispatch: S_BRANCH,   alu_op: ALU_BEQ,  legal: 1'b1};
      OP_BNE:   dec = '{dispatch: S_BRANCH,   alu_op: ALU_BNE,  legal: 1'b1};
      OP_BGTZ:  if (BGTZ_EN) dec = '{dispatch: S_BRANCH, alu_op: ALU_BGTZ, legal: 1'b1};
      OP_J:     dec = '{dispatch: S_JUMP,     alu_op: 4'b0000,  legal: 1'b1};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter bit BGTZ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mc_control_unit_if.master bus
);

  state_t     state;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  dec_t       dec;
  logic [3:0] alu_code;

  // In DECODE the live opcode drives dispatch; afterwards the latched copy is used.
  assign dec_op = (state == S_DECODE) ? bus.OP : op_q;

  mc_opcode_decode #(.BGTZ_EN(BGTZ_EN)) u_decode (
    .op  (dec_op),
    .dec (dec)
  );

  // State register and opcode latch
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        S_IDLE:     state <= S_FETCH;
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= bus.OP;
          state <= dec.legal ? dec.dispatch : S_FETCH;
        end
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state <= S_WB_MEM;
        S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Datapath control decode from the current state (plus mem_ready in wait states)
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_RT;
    bus.PCSource    = PCSRC_ALU;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    alu_code        = 4'b0000;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB    = SRCB_IMM_SH;
        bus.illegal_op = ~dec.legal;
        bus.instr_done = ~dec.legal;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        alu_code    = ALU_R;
      end
      S_WB_R: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        alu_code    = dec.alu_op;
      end
      S_WB_I: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_WB_MEM: begin
        bus.RegWrite   = 1'b1;
        bus.MemToReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        bus.instr_done  = 1'b1;
        alu_code        = dec.alu_op;
      end
      S_JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = PCSRC_JUMP;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Branch = bus.PCWriteCond;
  assign bus.ALUOP  = ALUOP_W'(alu_code);

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle successor to the single-cycle MIPS main decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the multi-cycle datapath: shared memory, IR, PC mux and ALU source muxes. It waits on a memory-ready handshake and flags unsupported opcodes. It sits between the instruction register opcode field and the datapath control inputs, and replaces the combinational decoder in the multi-cycle core.

## Interface
Parameters:
- ALUOP_W, 4: width of ALUOP; must be ≥ 4, codes zero-extended.
- BGTZ_EN, 1: 1 = bgtz supported; 0 = bgtz treated as illegal.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- OP, in, 6: opcode from IR[31:26]; sampled in DECODE.
- mem_ready, in, 1: memory access completes this cycle.
- PCWrite, out, 1: unconditional PC load.
- PCWriteCond, out, 1: PC load if branch condition true (Branch alias).
- Branch, out, 1: same as PCWriteCond, kept for datapath compatibility.
- IorD, out, 1: 0 = memory address from PC, 1 = from ALUOut.
- IRWrite, out, 1: load IR.
- MemRead, out, 1: memory read strobe.
- MemWrite, out, 1: memory write strobe.
- MemToReg, out, 1: write-back from MDR.
- RegDst, out, 1: destination rd (1) / rt (0).
- RegWrite, out, 1: register file write.
- ALUSrcA, out, 1: 0 = PC, 1 = rs.
- ALUSrcB, out, 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSource, out, 2: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUOP, out, ALUOP_W: operation code for ALU control.
- instr_done, out, 1: one-cycle pulse in the last state of each instruction.
- illegal_op, out, 1: one-cycle pulse in DECODE for an unsupported OP.

## Operation
- States:
  - IDLE: reset state. All outputs 0. Goes to FETCH unconditionally.
  - FETCH:
    - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=0000, PCSource=00.
    - IRWrite and PCWrite are asserted only while mem_ready=1.
    - Stays in FETCH while mem_ready=0, then goes to DECODE.
  - DECODE:
    - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOP=0000 (branch target precompute).
    - Dispatch on OP: 000000 → EXEC_R; 001000/001101/001100/001010 → EXEC_I; 100011/101011 → MEM_ADDR; 000100/000101/000111 → BRANCH; 000010 → JUMP.
    - Any other OP: illegal_op=1, instr_done=1, next state FETCH.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOP=0010 → WB_R.
  - WB_R: RegWrite=1, RegDst=1, MemToReg=0, instr_done=1 → FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOP from the table below → WB_I.
  - WB_I: RegWrite=1, RegDst=0, MemToReg=0, instr_done=1 → FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP = 0100 (lw) / 0101 (sw) → MEM_RD or MEM_WR.
  - MEM_RD: MemRead=1, IorD=1. Held until mem_ready=1 → WB_MEM.
  - WB_MEM: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1 → FETCH.
  - MEM_WR: MemWrite=1, IorD=1. Held until mem_ready=1; instr_done=1 in the completing cycle → FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=Branch=1, PCSource=01, instr_done=1 → FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1 → FETCH.
- ALUOP table (zero-extended to ALUOP_W): addi 0000, ori 0001, R 0010, andi 0011, lw 0100, sw 0101, slti 0110, beq 0111, bne 1000, bgtz 1001.
- Any output not listed for a state is 0.
- OP is latched into an internal register in DECODE. Later states use the latched copy, so OP changes after DECODE have no effect.

## Timing
- State register and latched opcode update on the clk rising edge.
- Outputs are combinational from the state, plus mem_ready in FETCH, MEM_RD and MEM_WR.
- rst=1 at an edge forces IDLE, whatever the current state, including mid-instruction or a memory wait. While in IDLE all outputs are 0, with no partial MemWrite or RegWrite.
- Latency with mem_ready tied to 1, counted from the FETCH cycle to instr_done inclusive:
  - j, beq, bne, bgtz: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - illegal OP: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. During a stall, strobes stay held and IRWrite/PCWrite stay 0.
- After the final state, the next cycle is always FETCH; there is no idle gap.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state enum;
  - opcode localparams: OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW, OP_SLTI, OP_BEQ, OP_BNE, OP_BGTZ, OP_J;
  - ALUOP code localparams;
  - ALUSrcB and PCSource encodings.
- One sub-module is natural: mc_opcode_decode, combinational. It maps OP to {dispatch state, ALUOP, legal}. The FSM instantiates it in DECODE.

## Test plan
- Reset then R-type (OP=000000, mem_ready=1) → states IDLE, FETCH, DECODE, EXEC_R, WB_R. RegWrite=1 and RegDst=1 in cycle 4; ALUOP=0010 in EXEC_R; instr_done in cycle 4.
- lw (100011) with mem_ready held low for 2 cycles in MEM_RD → MemRead=1 and IorD=1 for 3 cycles. WB_MEM follows with MemToReg=1 and RegWrite=1; total 7 cycles.
- sw (101011), then beq (000100), then j (000010) → MemWrite pulses exactly once. PCWriteCond=1 with PCSource=01 in the BRANCH cycle; PCWrite=1 with PCSource=10 in the JUMP cycle. instr_done appears 3 times.
- OP=111111, and separately OP=000111 with BGTZ_EN=0 → illegal_op=1 in DECODE, no RegWrite, MemWrite or PCWrite, next state FETCH.
- rst asserted during the MEM_WR stall → MemWrite=0 the cycle after the edge, state IDLE, then FETCH.
- ALUOP_W=6 with ori → ALUOP=000001 in EXEC_I.
